// File: rtl/tbird_switch_conditioner.sv
// tbird_switch_conditioner: sync+debounce left/right/hazard/brake (clock,reset,*_raw) into 3-bit switch code with switch_changed strobe and hazard_on; TBIRD_HAZARD_LATCH_EN makes hazard a press-toggle latch
module tbird_switch_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       left_raw,
  input  logic       right_raw,
  input  logic       hazard_raw,
  input  logic       brake_raw,
  output logic [2:0] switch,
  output logic       switch_changed,
  output logic       hazard_on
);
  logic [3:0] raw, s1, s2, stable;
  logic [DB_W-1:0] cnt [4];
  logic haz;
  logic [2:0] next_code;
  assign raw = {brake_raw, hazard_raw, left_raw, right_raw};
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 4; i++)
        if (s2[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          stable[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  end
`ifdef TBIRD_HAZARD_LATCH_EN
  logic haz_prev;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      haz_prev <= 1'b0;
      hazard_on <= 1'b0;
    end else begin
      haz_prev <= stable[2];
      if (stable[2] & ~haz_prev) hazard_on <= ~hazard_on;
    end
  end
  assign haz = hazard_on;
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) hazard_on <= 1'b0;
    else hazard_on <= stable[2];
  end
  assign haz = stable[2];
`endif
  assign next_code = {stable[3], haz ? 2'b11 : {stable[1] & ~stable[0], stable[0] & ~stable[1]}};
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      switch <= 3'b000;
      switch_changed <= 1'b0;
    end else begin
      switch <= next_code;
      switch_changed <= next_code != switch;
    end
  end
endmodule

// File: tb/tb_tbird_switch_conditioner.sv
// tb_tbird_switch_conditioner: scoreboard bench for tbird_switch_conditioner
module tb_tbird_switch_conditioner;
  logic clock = 1'b0, reset = 1'b1;
  logic left_raw = 1'b0, right_raw = 1'b0, hazard_raw = 1'b0, brake_raw = 1'b0;
  logic [2:0] switch;
  logic switch_changed, hazard_on;
  logic [2:0] exp_q [$];
  int tests = 0, fails = 0;
  logic latch_en;
  tbird_switch_conditioner #(.DB_CYCLES(4), .DB_W(8)) dut (
    .clock(clock), .reset(reset), .left_raw(left_raw), .right_raw(right_raw),
    .hazard_raw(hazard_raw), .brake_raw(brake_raw), .switch(switch),
    .switch_changed(switch_changed), .hazard_on(hazard_on)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clock)
    if (!reset && switch_changed) begin
      if (exp_q.size() == 0) check("spurious_pulse", {5'b0, switch}, 8'hff);
      else check("code", {5'b0, switch}, {5'b0, exp_q.pop_front()});
    end
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic hazard_press(input logic lvl);
    for (int i = 0; i < 4; i++) begin
      hazard_raw = (i % 2 == 0) ? lvl : ~lvl;
      cycles(1);
    end
    hazard_raw = lvl;
    cycles(14);
  endtask
  initial begin
    int lat;
`ifdef TBIRD_HAZARD_LATCH_EN
    latch_en = 1'b1;
`else
    latch_en = 1'b0;
`endif
    cycles(3);
    check("rst_switch", {5'b0, switch}, 8'h00);
    check("rst_changed", {7'b0, switch_changed}, 8'h00);
    check("rst_hazard", {7'b0, hazard_on}, 8'h00);
    reset = 1'b0;
    cycles(20);
    check("idle_switch", {5'b0, switch}, 8'h00);
    right_raw = 1'b1;
    exp_q.push_back(3'b001);
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(posedge clock);
      #1;
      if (switch_changed) lat = i;
    end
    check("right_latency", 8'(lat), 8'd7);
    @(posedge clock);
    #1;
    check("pulse_width", {7'b0, switch_changed}, 8'h00);
    cycles(2);
    right_raw = 1'b0;
    exp_q.push_back(3'b000);
    cycles(12);
    left_raw = 1'b1;
    cycles(3);
    left_raw = 1'b0;
    cycles(15);
    check("glitch_switch", {5'b0, switch}, 8'h00);
    left_raw = 1'b1;
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b000);
    cycles(5);
    left_raw = 1'b0;
    cycles(20);
    left_raw = 1'b1;
    right_raw = 1'b1;
    cycles(12);
    check("lever_fault", {5'b0, switch}, 8'h00);
    right_raw = 1'b0;
    brake_raw = 1'b1;
    exp_q.push_back(3'b110);
    cycles(12);
    left_raw = 1'b0;
    exp_q.push_back(3'b100);
    cycles(12);
    right_raw = 1'b1;
    exp_q.push_back(3'b101);
    cycles(12);
    right_raw = 1'b0;
    brake_raw = 1'b0;
    exp_q.push_back(3'b000);
    cycles(12);
    exp_q.push_back(3'b011);
    hazard_press(1'b1);
    check("haz_on1", {7'b0, hazard_on}, 8'h01);
    brake_raw = 1'b1;
    exp_q.push_back(3'b111);
    cycles(12);
    if (!latch_en) exp_q.push_back(3'b100);
    hazard_press(1'b0);
    check("haz_release", {7'b0, hazard_on}, {7'b0, latch_en});
    exp_q.push_back(latch_en ? 3'b100 : 3'b111);
    hazard_press(1'b1);
    check("haz_on2", {7'b0, hazard_on}, {7'b0, ~latch_en});
    if (!latch_en) exp_q.push_back(3'b100);
    hazard_press(1'b0);
    check("haz_off", {7'b0, hazard_on}, 8'h00);
    brake_raw = 1'b0;
    exp_q.push_back(3'b000);
    cycles(12);
    right_raw = 1'b1;
    exp_q.push_back(3'b001);
    cycles(12);
    brake_raw = 1'b1;
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b1;
    right_raw = 1'b0;
    #1;
    check("async_rst_switch", {5'b0, switch}, 8'h00);
    check("async_rst_changed", {7'b0, switch_changed}, 8'h00);
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    cycles(3);
    reset = 1'b0;
    exp_q.push_back(3'b100);
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(posedge clock);
      #1;
      if (switch_changed) lat = i;
    end
    check("post_rst_latency", 8'(lat), 8'd7);
    cycles(12);
    check("final_switch", {5'b0, switch}, 8'h04);
    check("final_queue", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tbird_switch_conditioner.md
Name: tbird_switch_conditioner

Overview:
- Input stage directly upstream of the T-bird tail-light sequencer.
- Takes raw lever, hazard and brake contacts, then synchronises and debounces them.
- Latches hazard (toggle) and encodes the result into the 3-bit switch code that the sequencer consumes.
- Emits a one-cycle change strobe so the sequencer's pattern restart is driven by clean, debounced transitions only.

Parameters:
- DB_CYCLES, 4: consecutive samples a synchronised input must differ from its stable value before the new level is accepted; legal range 1..255.
- DB_W, 8: debounce counter width; must hold DB_CYCLES-1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- left_raw  input  1  left-turn lever contact, asynchronous, may bounce.
- right_raw  input  1  right-turn lever contact, asynchronous, may bounce.
- hazard_raw  input  1  hazard push-button, asynchronous, may bounce.
- brake_raw  input  1  brake pedal contact, asynchronous, may bounce.
- switch  output  3  encoded code to sequencer, registered.
- switch_changed  output  1  one-cycle pulse, high in the first cycle switch shows a new value.
- hazard_on  output  1  current hazard state, registered.

Behaviour:
- Reset: asynchronous, active-high. Clears everything to 0:
  - synchroniser flops, debounce counters, stable levels;
  - hazard_on=0, switch=3'b000, switch_changed=0.
- Reset mid-debounce discards partial counts. After release, no switch_changed pulse occurs unless a new qualified change follows.
- Synchroniser: 2-flop chain per raw input.
- Debouncer (per input): stable level plus counter.
  - If sync == stable: counter <= 0.
  - Else if counter == DB_CYCLES-1: stable <= sync, counter <= 0.
  - Else: counter <= counter+1.
  - Any sample agreeing with stable restarts the count, so a glitch shorter than DB_CYCLES samples is never accepted.
- Hazard latch: a rising edge of debounced hazard (registered previous value) toggles hazard_on. A level held high does not re-toggle.
- Encoding, computed from debounced levels:
  - bit2 = brake.
  - bits[1:0] = 2'b11 when hazard_on.
  - Otherwise bits[1:0] = {left & ~right, right & ~left}.
  - Left and right both high (lever fault) gives 2'b00.
  - Resulting codes:
    - 000 idle, 001 right, 010 left, 011 hazard;
    - 100 brake, 101 brake+right, 110 brake+left, 111 brake+hazard.
- Output register: switch <= next_code; switch_changed <= (next_code != switch). The pulse is exactly one cycle per change; consecutive distinct changes give consecutive pulses.
- Latency: a raw level change occurring between edges appears on switch at the (DB_CYCLES+3)th following rising edge.
  - 2 synchroniser edges, then DB_CYCLES debounce edges, then 1 encode edge.
  - The hazard path adds 1 edge for the latch.
- Simultaneous debounced changes on several inputs in one cycle produce a single new code and a single pulse.

Optional Feature:
- Macro: TBIRD_HAZARD_LATCH_EN.
- Defined: hazard_on is the toggle latch described above; one press turns hazard on, the next press turns it off.
- Undefined: no latch and no edge-detect flop. hazard_on equals the debounced hazard level (registered with the same latency as the other inputs); hazard is active only while the button is held.

Test Plan:
(All scenarios use DB_CYCLES=4.)
- Assert reset at time 0, then release -> switch=000, switch_changed=0, hazard_on=0; no pulse for 20 cycles after release.
- right_raw 0->1 held -> switch=001 on the 7th rising edge after the change; switch_changed high for exactly that one cycle, then 0.
- left_raw high for 3 cycles then low (glitch) -> switch stays 000 and switch_changed never asserts. Repeat with a 5-cycle pulse -> 010 appears, then returns to 000 after release plus 7 edges, one pulse each.
- left_raw and right_raw both high -> 000. Then brake_raw high with left only -> 110. Brake alone -> 100. Brake with right -> 101.
- hazard_raw pressed for 10 cycles with bouncing edges -> hazard_on=1 and switch=011. Add brake -> 111. Second press -> hazard_on=0, switch=100. With TBIRD_HAZARD_LATCH_EN undefined, hazard is 011 only while held.
- Assert reset asynchronously with brake held mid-debounce (counter at 2) -> switch=000 immediately, without waiting for a clock edge. After release with brake still held -> 100 after 7 edges, one pulse.
